// File: rtl/ctle_stream_pkg.sv
// ctle_stream_pkg: shared types and helpers for the CTLE streaming driver.
//   state_e   - driver FSM states
//   MAX_CH    - largest supported channel count
//   MAX_W     - working width of the clamp helpers (all words sign-extended to it)
//   clamp_val - symmetric clamp of v to [-lim, lim]
//   clamp_hit - 1 when clamp_val changed v
package ctle_stream_pkg;

    localparam int unsigned MAX_CH = 16;
    localparam int unsigned MAX_W  = 32;

    typedef enum logic [2:0] {StIdle, StStep, StWait, StCapture, StHold} state_e;

    // Callers sign-extend narrower words to MAX_W, which parametrises this on width.
    function automatic logic signed [MAX_W-1:0] clamp_val(input logic signed [MAX_W-1:0] v,
                                                          input logic signed [MAX_W-1:0] lim);
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

    function automatic logic clamp_hit(input logic signed [MAX_W-1:0] v,
                                       input logic signed [MAX_W-1:0] lim);
        return (v > lim) || (v < -lim);
    endfunction

endpackage

// File: rtl/ctle_interp_model.sv
// ctle_interp_model: stand-in for the generated interpolating CTLE model.
// Each channel accumulates its input on cke; the result is visible the cycle
// after the step, well inside any MODEL_LAT >= 0 the driver waits out.
//   clk, rst  clock and asynchronous active-high reset
//   cke       step enable
//   dt        timestep (not used by this stand-in)
//   in_data   N_CH packed signed inputs
//   out_data  N_CH packed signed outputs
module ctle_interp_model #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned IN_WIDTH  = 18,
    parameter int unsigned OUT_WIDTH = 18,
    parameter int unsigned DT_WIDTH  = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cke,
    input  logic [DT_WIDTH-1:0]       dt,
    input  logic [N_CH*IN_WIDTH-1:0]  in_data,
    output logic [N_CH*OUT_WIDTH-1:0] out_data
);

    logic dt_unused;
    assign dt_unused = ^dt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (cke) begin
            for (int k = 0; k < int'(N_CH); k++) begin
                out_data[k*OUT_WIDTH +: OUT_WIDTH] <= out_data[k*OUT_WIDTH +: OUT_WIDTH]
                    + OUT_WIDTH'($signed(in_data[k*IN_WIDTH +: IN_WIDTH]));
            end
        end
    end

endmodule

// File: rtl/ctle_out_clamp.sv
// ctle_out_clamp: combinational symmetric clamp of one channel's model output.
//   v   in  WIDTH  signed model value
//   y   out WIDTH  value clamped to [-LIMIT, LIMIT]
//   sat out 1      clamp was applied
module ctle_out_clamp
    import ctle_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int          LIMIT = (1 << (WIDTH - 1)) - 1
) (
    input  logic signed [WIDTH-1:0] v,
    output logic        [WIDTH-1:0] y,
    output logic                    sat
);

    logic signed [MAX_W-1:0] v_ext;
    logic signed [MAX_W-1:0] lim;

    assign v_ext = MAX_W'(v);
    assign lim   = LIMIT;
    assign y     = WIDTH'(clamp_val(v_ext, lim));
    assign sat   = clamp_hit(v_ext, lim);

endmodule

// File: rtl/ctle_interp_stream.sv
// ctle_interp_stream: streaming driver around the CTLE model.
// Accepts a frame (samples, dt, step count), steps the model that many times,
// then holds clamped outputs until the consumer takes them.
//   clk, rst              clock, asynchronous active-high reset (also resets model)
//   in_valid/in_ready     input frame handshake
//   in_data/in_dt/in_steps  frame contents, latched on accept
//   out_valid/out_ready   result handshake
//   out_data/out_sat      clamped outputs and per-channel clamp flags
module ctle_interp_stream
    import ctle_stream_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned IN_WIDTH  = 18,
    parameter int unsigned OUT_WIDTH = 18,
    parameter int unsigned DT_WIDTH  = 18,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned MODEL_LAT = 1,
    parameter int          OUT_LIMIT = (1 << (OUT_WIDTH - 1)) - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_CH*IN_WIDTH-1:0]  in_data,
    input  logic [DT_WIDTH-1:0]       in_dt,
    input  logic [STEP_W-1:0]         in_steps,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CH*OUT_WIDTH-1:0] out_data,
    output logic [N_CH-1:0]           out_sat
);

    state_e                     state_q;
    logic [N_CH*IN_WIDTH-1:0]   data_q;
    logic [DT_WIDTH-1:0]        dt_q;
    logic [STEP_W-1:0]          cnt_q;
    logic [2:0]                 wait_q;
    logic                       cke;
    logic [N_CH*OUT_WIDTH-1:0]  model_out;
    logic [N_CH*OUT_WIDTH-1:0]  clamp_data;
    logic [N_CH-1:0]            clamp_sat;

    assign cke = (state_q == StStep);

    ctle_interp_model #(
        .N_CH      (N_CH),
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .DT_WIDTH  (DT_WIDTH)
    ) u_model (
        .clk      (clk),
        .rst      (rst),
        .cke      (cke),
        .dt       (dt_q),
        .in_data  (data_q),
        .out_data (model_out)
    );

    for (genvar k = 0; k < int'(N_CH); k++) begin : g_clamp
        ctle_out_clamp #(
            .WIDTH (OUT_WIDTH),
            .LIMIT (OUT_LIMIT)
        ) u_clamp (
            .v   (model_out[k*OUT_WIDTH +: OUT_WIDTH]),
            .y   (clamp_data[k*OUT_WIDTH +: OUT_WIDTH]),
            .sat (clamp_sat[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
            data_q    <= '0;
            dt_q      <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        dt_q     <= in_dt;
                        cnt_q    <= in_steps;
                        in_ready <= 1'b0;
                        state_q  <= (in_steps != '0) ? StStep : StCapture;
                    end
                end
                StStep: begin
                    cnt_q <= cnt_q - STEP_W'(1);
                    if (MODEL_LAT > 0) begin
                        wait_q  <= 3'(MODEL_LAT - 1);
                        state_q <= StWait;
                    end else if (cnt_q > STEP_W'(1)) begin
                        // Counter still nonzero after this step's decrement.
                        state_q <= StStep;
                    end else begin
                        state_q <= StCapture;
                    end
                end
                StWait: begin
                    if (wait_q != 3'd0) begin
                        wait_q <= wait_q - 3'd1;
                    end else begin
                        state_q <= (cnt_q != '0) ? StStep : StCapture;
                    end
                end
                StCapture: begin
                    out_data  <= clamp_data;
                    out_sat   <= clamp_sat;
                    out_valid <= 1'b1;
                    state_q   <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctle_interp_stream.sv
module tb_ctle_interp_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [17:0] dt;

    // A: 4 ch, 18-bit, MODEL_LAT=1
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [71:0] a_in_data, a_out_data;
    logic [7:0]  a_in_steps;
    logic [3:0]  a_out_sat;
    // B: 4 ch, 8-bit, OUT_LIMIT=100
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_in_steps;
    logic [3:0]  b_out_sat;
    // C: 16 ch, MODEL_LAT=0
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [287:0] c_in_data, c_out_data;
    logic [7:0]   c_in_steps;
    logic [15:0]  c_out_sat;

    ctle_interp_stream #(.N_CH(4), .MODEL_LAT(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_dt(dt), .in_steps(a_in_steps), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_sat(a_out_sat)
    );

    ctle_interp_stream #(.N_CH(4), .IN_WIDTH(8), .OUT_WIDTH(8), .MODEL_LAT(1),
                         .OUT_LIMIT(100)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_dt(dt), .in_steps(b_in_steps), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_sat(b_out_sat)
    );

    ctle_interp_stream #(.N_CH(16), .MODEL_LAT(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_dt(dt), .in_steps(c_in_steps), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_sat(c_out_sat)
    );

    typedef struct {
        logic [71:0]       din;
        int                steps;
        logic [3:0][31:0]  ex;
        int                sat;
        int                lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] din4(input int d0, input int d1, input int d2, input int d3);
        logic [71:0] r;
        r[17:0]  = 18'(d0);
        r[35:18] = 18'(d1);
        r[53:36] = 18'(d2);
        r[71:54] = 18'(d3);
        return r;
    endfunction

    function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                                input int steps, input int e0, input int e1, input int e2,
                                input int e3, input int sat, input int lat);
        vec_t v;
        v.din   = din4(d0, d1, d2, d3);
        v.steps = steps;
        v.ex[0] = e0;
        v.ex[1] = e1;
        v.ex[2] = e2;
        v.ex[3] = e3;
        v.sat   = sat;
        v.lat   = lat;
        return v;
    endfunction

    function automatic int a_ch(input int k);
        return int'($signed(a_out_data[k*18 +: 18]));
    endfunction

    function automatic int b_ch(input int k);
        return int'($signed(b_out_data[k*8 +: 8]));
    endfunction

    function automatic int c_ch(input int k);
        return int'($signed(c_out_data[k*18 +: 18]));
    endfunction

    // Leaves time at #1 after the accept edge.
    task automatic a_start(input logic [71:0] d, input int steps);
        int guard = 0;
        while (!a_in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!a_in_ready) check("a_in_ready_timeout", 0, 1);
        a_in_data  = d;
        a_in_steps = 8'(steps);
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_start(input int d0, input int d1, input int steps);
        b_in_data  = {8'd0, 8'd0, 8'(d1), 8'(d0)};
        b_in_steps = 8'(steps);
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    // lat = number of edges after the accept edge until out_valid is seen.
    task automatic wait_valid(input int which, output int lat);
        logic v;
        lat = 0;
        v = (which == 0) ? a_out_valid : (which == 1) ? b_out_valid : c_out_valid;
        while (!v && lat < 600) begin
            @(posedge clk); #1;
            lat++;
            v = (which == 0) ? a_out_valid : (which == 1) ? b_out_valid : c_out_valid;
        end
    endtask

    task automatic ack(input int which);
        if (which == 0) a_out_ready = 1'b1;
        else if (which == 1) b_out_ready = 1'b1;
        else c_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        c_out_ready = 1'b0;
    endtask

    initial begin
        vec_t tbl[4];
        int   lat;
        int   snap;

        rst = 1'b1;
        dt  = 18'd77;
        a_in_valid = 0; a_out_ready = 0; a_in_data = '0; a_in_steps = '0;
        b_in_valid = 0; b_out_ready = 0; b_in_data = '0; b_in_steps = '0;
        c_in_valid = 0; c_out_ready = 0; c_in_data = '0; c_in_steps = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_in_ready", int'(a_in_ready), 1);
        check("reset_out_valid", int'(a_out_valid), 0);
        check("reset_out_data", int'(a_out_data != '0), 0);
        check("reset_out_sat", int'(a_out_sat), 0);

        // Model accumulates across frames; held inputs change only on accept.
        tbl[0] = mk( 1, 2,  3,  4, 3, 3, 6,  9, 12, 0, 7);
        tbl[1] = mk( 9, 9,  9,  9, 0, 3, 6,  9, 12, 0, 1);
        tbl[2] = mk(-1, 0, 10, -5, 2, 1, 6, 29,  2, 0, 5);
        tbl[3] = mk( 0, -6, 0,  1, 1, 1, 0, 29,  3, 0, 3);

        for (int i = 0; i < 4; i++) begin
            a_start(tbl[i].din, tbl[i].steps);
            wait_valid(0, lat);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            for (int k = 0; k < 4; k++)
                check($sformatf("vec%0d_ch%0d", i, k), a_ch(k), int'($signed(tbl[i].ex[k])));
            check($sformatf("vec%0d_sat", i), int'(a_out_sat), tbl[i].sat);
            ack(0);
            check($sformatf("vec%0d_ready_after_ack", i), int'(a_in_ready), 1);
        end

        // Backpressure in HOLD with a competing frame offered.
        a_start(din4(1, 1, 1, 1), 1);
        wait_valid(0, lat);
        check("hold_latency", lat, 3);
        snap = a_ch(2);
        check("hold_ch2", snap, 30);
        a_in_data  = din4(2, 2, 2, 2);
        a_in_steps = 8'd0;
        a_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold_in_ready_c%0d", c), int'(a_in_ready), 0);
            check($sformatf("hold_out_valid_c%0d", c), int'(a_out_valid), 1);
            check($sformatf("hold_stable_c%0d", c), a_ch(2), 30);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check("post_ack_in_ready", int'(a_in_ready), 1);
        check("post_ack_out_valid", int'(a_out_valid), 0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("second_accept", int'(a_in_ready), 0);
        wait_valid(0, lat);
        check("second_latency", lat, 1);
        check("second_ch0", a_ch(0), 2);
        check("second_ch3", a_ch(3), 4);
        ack(0);

        // Saturation on the narrow instance.
        b_start(60, 0, 2);
        wait_valid(1, lat);
        check("b1_latency", lat, 5);
        check("b1_ch0", b_ch(0), 100);
        check("b1_ch1", b_ch(1), 0);
        check("b1_sat", int'(b_out_sat), 1);
        ack(1);
        b_start(0, 0, 0);
        wait_valid(1, lat);
        check("b2_latency", lat, 1);
        check("b2_ch0", b_ch(0), 100);
        check("b2_sat", int'(b_out_sat), 1);
        ack(1);
        b_start(0, -60, 2);
        wait_valid(1, lat);
        check("b3_ch0", b_ch(0), 100);
        check("b3_ch1", b_ch(1), -100);
        check("b3_ch2", b_ch(2), 0);
        check("b3_sat", int'(b_out_sat), 3);
        ack(1);

        // 16 channels, zero model latency, 255 steps.
        for (int k = 0; k < 16; k++) c_in_data[k*18 +: 18] = 18'(k);
        c_in_steps = 8'd255;
        c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        wait_valid(2, lat);
        check("c_latency", lat, 256);
        for (int k = 0; k < 16; k++)
            check($sformatf("c_ch%0d", k), c_ch(k), 255 * k);
        check("c_sat", int'(c_out_sat), 0);
        ack(2);

        // Reset in WAIT of a 10-step frame.
        a_start(din4(7, 7, 7, 7), 10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", int'(a_in_ready), 1);
        check("rst_out_valid", int'(a_out_valid), 0);
        check("rst_out_data", int'(a_out_data != '0), 0);
        check("rst_out_sat", int'(a_out_sat), 0);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("rst_no_partial", int'(a_out_valid), 0);
        a_start(din4(5, 5, 5, 5), 1);
        wait_valid(0, lat);
        check("fresh_latency", lat, 3);
        for (int k = 0; k < 4; k++)
            check($sformatf("fresh_ch%0d", k), a_ch(k), 5);
        check("fresh_sat", int'(a_out_sat), 0);
        ack(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctle_interp_stream.md
# ctle_interp_stream

Parametrised N-channel streaming driver for the generated interpolating CTLE model. It accepts frames of fixed-point channel samples plus a timestep through a valid/ready handshake and holds them zero-order. It steps the model a programmable number of times, then presents saturated per-channel outputs through a second valid/ready handshake. It supersedes the fixed 4-channel free-running wrapper and is the unit the emulator streaming bench and FPGA host interface instantiate.

## Interface
- N_CH, 4: channel count, 1..16
- IN_WIDTH, 18: signed fixed-point input word width per channel
- OUT_WIDTH, 18: signed fixed-point output word width per channel
- DT_WIDTH, 18: unsigned timestep word width
- STEP_W, 8: width of the step-count field
- MODEL_LAT, 1: cycles from model step to valid model output, 0..7
- OUT_LIMIT, 2**(OUT_WIDTH-1)-1: symmetric output clamp magnitude

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset; also drives model reset
- in_valid  in  1  frame offered
- in_ready  out  1  frame accepted when in_valid && in_ready
- in_data  in  N_CH*IN_WIDTH  channel k at [k*IN_WIDTH +: IN_WIDTH]
- in_dt  in  DT_WIDTH  timestep for every step of this frame
- in_steps  in  STEP_W  number of model steps, 0 allowed
- out_valid  out  1  result frame held
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  N_CH*OUT_WIDTH  clamped outputs, same packing as in_data
- out_sat  out  N_CH  per-channel flag: clamp applied in this result frame

## Operation
- Reset: state IDLE, in_ready=1, out_valid=0, out_data=0, out_sat=0, step counter=0, held input and dt registers=0; model state cleared.
- FSM states:
  - IDLE: in_ready=1. On accept, latch in_data, in_dt and in_steps. Go to STEP if in_steps>0, else CAPTURE.
  - STEP: assert model cke for exactly one cycle; decrement counter. Go to WAIT if MODEL_LAT>0, else to STEP while counter>0, else CAPTURE.
  - WAIT: count MODEL_LAT cycles. Then go to STEP if counter>0, else CAPTURE.
  - CAPTURE: register clamped model outputs into out_data/out_sat. Go to HOLD.
  - HOLD: out_valid=1, out_data stable. On out_ready go to IDLE.
- in_ready is 0 in every state except IDLE. in_data is ignored outside the accept cycle. Held inputs persist to the model between frames.
- Clamp: model value v is signed OUT_WIDTH. If v>OUT_LIMIT, output OUT_LIMIT and set sat; if v<-OUT_LIMIT, output -OUT_LIMIT and set sat. out_sat is per frame, not sticky.
- Model state is never cleared between frames; only rst clears it.
- rst asserted in any state: immediate return to reset values. A frame in flight is discarded and no partial result is emitted.

## Timing
- Accept at edge T; out_valid rises at edge T + in_steps*(1+MODEL_LAT) + 1. For in_steps=0 this is T+1.
- Earliest next accept: the cycle after the out_ready handshake. A back-to-back frame with out_ready held high costs 1 idle cycle per frame.
- out_valid, once high, stays high with stable out_data/out_sat until handshake, regardless of in_valid.
- The model sees cke only in STEP; dt and input ports are driven from held registers every cycle.

## Structure
- Package ctle_stream_pkg: state enum (IDLE, STEP, WAIT, CAPTURE, HOLD), MAX_CH=16, and the clamp function parametrised on width and limit.
- Sub-module ctle_out_clamp: one instance per channel via generate, combinational clamp plus sat bit, registered in CAPTURE by the parent.
- The generated model exposes clk, rst, cke, dt, and in_k/out_k per channel.

## Test plan
Run with stub model: out_k <= out_k + in_k on cke, LAT = MODEL_LAT.
- N_CH=4, MODEL_LAT=1, in_data={1,2,3,4}, in_steps=3 -> out_valid at T+7, out_data={3,6,9,12}, out_sat=0.
- in_steps=0 after the previous frame -> out_valid at T+1, out_data unchanged {3,6,9,12}.
- OUT_WIDTH=8, OUT_LIMIT=100, ch0 input 60, in_steps=2 -> ch0 out 100, out_sat[0]=1, others 0. A second frame with input 0 and in_steps=0 leaves the model value 120, so out_data is 100 and out_sat[0]=1 again.
- out_ready low for 5 cycles in HOLD with in_valid high -> in_ready stays 0, out_data stable, no second accept until the cycle after the handshake.
- Assert rst during WAIT of a 10-step frame -> next cycle in_ready=1, out_valid=0, all outputs 0. A fresh frame {5,...}, in_steps=1, yields out_data={5,...}.
- N_CH=16, MODEL_LAT=0, ramp inputs k, in_steps=255 -> out_valid at T+256, channel k out = 255*k (k=0..15).
